fpu_sqrt_iter: RTL and testbench

FPU_SQRT_ITER -- requirements
Module: fpu_sqrt_iter

---
 rtl/fpu_sqrt_iter.sv | 211 +++++++++++++++++++++
 tb/tb_fpu_sqrt_iter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sqrt_iter.sv
// Iterative significand square root: normalise, restoring digit recurrence, sticky.
// Define FPU_SQRT_RADIX4_EN to retire two root bits per cycle instead of one.
module fpu_sqrt_iter #(
  parameter int SIG_W = 24,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic             is_subnormal,
  input  logic             in_exp0,
  input  logic [EXP_W-1:0] exp_half,
  input  logic [SIG_W-1:0] in_sig,
  output logic             busy,
  output logic             sqrt_done,
  output logic [SIG_W+2:0] sqrt_proNorm_sig,
  output logic [EXP_W-1:0] sqrt_proNorm_exp,
  output logic             uf
);

  localparam int Q   = SIG_W + 2;
`ifdef FPU_SQRT_RADIX4_EN
  localparam int BPC = 2;
`else
  localparam int BPC = 1;
`endif
  localparam int N   = (Q + BPC - 1) / BPC;
  localparam int QX  = N * BPC;
  localparam int RW  = 2 * QX;
  localparam int RMW = QX + 2;
  localparam int LZW = $clog2(SIG_W + 1);
  localparam int CW  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic               op_sub_q, op_sub_d;
  logic               op_exp0_q, op_exp0_d;
  logic [EXP_W-1:0]   op_eh_q, op_eh_d;
  logic [SIG_W-1:0]   op_sig_q, op_sig_d;
  logic [SIG_W-1:0]   m_q, m_d;
  logic               odd_q, odd_d;
  logic               zero_q, zero_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      rad_q, rad_d;
  logic [RMW-1:0]     rem_q, rem_d;
  logic [QX-1:0]      root_q, root_d;
  logic [SIG_W+2:0]   res_sig_q, res_sig_d;
  logic [EXP_W-1:0]   res_exp_q, res_exp_d;
  logic               uf_q, uf_d;

  logic [LZW-1:0]     lz;
  logic [EXP_W-1:0]   half_lz;
  logic [RMW-1:0]     rem_t;
  logic [QX-1:0]      root_t;
  logic [RW-1:0]      rad_t;
  logic               sticky;

  function automatic logic [LZW-1:0] clz(input logic [SIG_W-1:0] v);
    logic [LZW-1:0] r;
    r = LZW'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (v[i]) r = LZW'(SIG_W - 1 - i);
    return r;
  endfunction

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  function automatic logic [RMW+QX-1:0] sqrt_step(input logic [RMW-1:0] rem,
                                                  input logic [QX-1:0] root,
                                                  input logic [1:0] pair);
    logic [RMW-1:0] rs;
    logic [RMW-1:0] trial;
    rs    = {rem[RMW-3:0], pair};
    trial = {root, 2'b01};
    if (rs >= trial) return {rs - trial, root[QX-2:0], 1'b1};
    else             return {rs, root[QX-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d   = state_q;
    op_sub_d  = op_sub_q;
    op_exp0_d = op_exp0_q;
    op_eh_d   = op_eh_q;
    op_sig_d  = op_sig_q;
    m_d       = m_q;
    odd_d     = odd_q;
    zero_d    = zero_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    res_sig_d = res_sig_q;
    res_exp_d = res_exp_q;
    uf_d      = uf_q;

    lz      = clz(op_sig_q);
    half_lz = EXP_W'(({1'b0, lz} + 1'b1) >> 1);

    rem_t  = rem_q;
    root_t = root_q;
    rad_t  = rad_q;
    for (int b = 0; b < BPC; b++) begin
      {rem_t, root_t} = sqrt_step(rem_t, root_t, rad_t[RW-1 -: 2]);
      rad_t = rad_t << 2;
    end
    // A padding root bit (odd Q in radix-4) is folded into sticky.
    sticky = (rem_t != '0) | ((QX > Q) && root_t[0]);

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d   = NORM;
          op_sub_d  = is_subnormal;
          op_exp0_d = in_exp0;
          op_eh_d   = exp_half;
          op_sig_d  = in_sig;
        end
      end
      NORM: begin
        if (op_sub_q) begin
          m_d   = op_sig_q << lz;
          odd_d = lz[0];
          exp_d = op_eh_q - half_lz;
        end else begin
          m_d   = op_sig_q;
          odd_d = !op_exp0_q;
          exp_d = op_eh_q;
        end
        zero_d  = op_sub_q && (op_sig_q == '0);
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          // Odd exponent doubles the radicand so the root lands in [1,2).
          rad_d  = {(odd_q ? {m_q, 1'b0} : {1'b0, m_q}), {(RW-SIG_W-1){1'b0}}};
          rem_d  = '0;
          root_d = '0;
        end else begin
          rad_d  = rad_t;
          rem_d  = rem_t;
          root_d = root_t;
          if (cnt_q == CW'(N)) begin
            state_d   = DONE;
            res_sig_d = zero_q ? '0 : {root_t[QX-1 -: Q], sticky};
            res_exp_d = zero_q ? '0 : exp_q;
            uf_d      = zero_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (kill && state_q != IDLE) begin
      state_d   = IDLE;
      res_sig_d = res_sig_q;
      res_exp_d = res_exp_q;
      uf_d      = uf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_sub_q  <= 1'b0;
      op_exp0_q <= 1'b0;
      op_eh_q   <= '0;
      op_sig_q  <= '0;
      m_q       <= '0;
      odd_q     <= 1'b0;
      zero_q    <= 1'b0;
      exp_q     <= '0;
      cnt_q     <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      res_sig_q <= '0;
      res_exp_q <= '0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_sub_q  <= op_sub_d;
      op_exp0_q <= op_exp0_d;
      op_eh_q   <= op_eh_d;
      op_sig_q  <= op_sig_d;
      m_q       <= m_d;
      odd_q     <= odd_d;
      zero_q    <= zero_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      res_sig_q <= res_sig_d;
      res_exp_q <= res_exp_d;
      uf_q      <= uf_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign sqrt_done        = (state_q == DONE);
  assign sqrt_proNorm_sig = res_sig_q;
  assign sqrt_proNorm_exp = res_exp_q;
  assign uf               = uf_q;

endmodule

// File: tb/tb_fpu_sqrt_iter.sv
// Scoreboard bench for fpu_sqrt_iter: directed vectors, kill, reset and busy-start cases.
module tb_fpu_sqrt_iter;
  localparam int SIG_W = 24;
  localparam int EXP_W = 8;
`ifdef FPU_SQRT_RADIX4_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 28;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              kill = 1'b0;
  logic              is_subnormal = 1'b0;
  logic              in_exp0 = 1'b0;
  logic [EXP_W-1:0]  exp_half = '0;
  logic [SIG_W-1:0]  in_sig = '0;
  logic              busy;
  logic              sqrt_done;
  logic [SIG_W+2:0]  sqrt_proNorm_sig;
  logic [EXP_W-1:0]  sqrt_proNorm_exp;
  logic              uf;

  fpu_sqrt_iter #(.SIG_W(SIG_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill),
    .is_subnormal(is_subnormal), .in_exp0(in_exp0), .exp_half(exp_half),
    .in_sig(in_sig), .busy(busy), .sqrt_done(sqrt_done),
    .sqrt_proNorm_sig(sqrt_proNorm_sig), .sqrt_proNorm_exp(sqrt_proNorm_exp), .uf(uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic        e0;
    logic [7:0]  eh;
    logic [23:0] s;
    logic [26:0] xs;
    logic [7:0]  xe;
    logic        xu;
  } vec_t;

  typedef struct {
    logic [26:0] xs;
    logic [7:0]  xe;
    logic        xu;
    int          acc;
  } sb_t;

  // Expected values derived by hand: root = floor(2^25*sqrt(X)), sticky = inexact.
  vec_t vecs [10] = '{
    '{1'b0, 1'b1, 8'h7F, 24'h800000, 27'h4000000, 8'h7F, 1'b0},  // sqrt(1)
    '{1'b0, 1'b0, 8'h7F, 24'h800000, 27'h5A82799, 8'h7F, 1'b0},  // sqrt(2)
    '{1'b1, 1'b0, 8'h40, 24'h000001, 27'h5A82799, 8'h34, 1'b0},  // subnormal lz=23
    '{1'b1, 1'b1, 8'h40, 24'h000000, 27'h0000000, 8'h00, 1'b1},  // subnormal zero
    '{1'b0, 1'b0, 8'h80, 24'h900000, 27'h6000000, 8'h80, 1'b0},  // sqrt(2.25)=1.5
    '{1'b0, 1'b1, 8'h3C, 24'hC80000, 27'h5000000, 8'h3C, 1'b0},  // sqrt(1.5625)=1.25
    '{1'b0, 1'b1, 8'h10, 24'h800001, 27'h4000003, 8'h10, 1'b0},  // 1+ulp, inexact
    '{1'b1, 1'b0, 8'h05, 24'h200000, 27'h4000000, 8'h04, 1'b0},  // subnormal lz=2
    '{1'b0, 1'b0, 8'hFE, 24'hFFFFFF, 27'h7FFFFFB, 8'hFE, 1'b0},  // largest radicand
    '{1'b1, 1'b1, 8'h20, 24'h400000, 27'h5A82799, 8'h1F, 1'b0}   // subnormal lz=1
  };

  sb_t sb [$];
  int  errors   = 0;
  int  checks   = 0;
  int  edge_cnt = 0;
  int  txn      = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every completion is matched against the oldest expected entry.
  always @(negedge clk) begin
    sb_t e;
    if (reset && sqrt_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: sig=%h exp=%h at edge %0d", sqrt_proNorm_sig, sqrt_proNorm_exp, edge_cnt);
      end else begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: sig=%h exp=%h uf=%b latency=%0d (want sig=%h exp=%h uf=%b latency=%0d)",
                 txn, sqrt_proNorm_sig, sqrt_proNorm_exp, uf, edge_cnt - e.acc, e.xs, e.xe, e.xu, LAT);
        check("sig", 32'(sqrt_proNorm_sig), 32'(e.xs));
        check("exp", 32'(sqrt_proNorm_exp), 32'(e.xe));
        check("uf", 32'(uf), 32'(e.xu));
        check("latency", edge_cnt - e.acc, LAT);
      end
    end
  end

  task automatic issue(input vec_t v, input bit do_push, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: busy=%b, expected 0 within 100 cycles", busy);
    end
    is_subnormal = v.sub;
    in_exp0      = v.e0;
    exp_half     = v.eh;
    in_sig       = v.s;
    start        = 1'b1;
    acc          = edge_cnt + 1;
    if (do_push) sb.push_back('{v.xs, v.xe, v.xu, acc});
    @(negedge clk);
    start        = 1'b0;
    // Disturb operands after acceptance; the result must not change.
    in_sig       = ~v.s;
    in_exp0      = ~v.e0;
    exp_half     = ~v.eh;
    is_subnormal = ~v.sub;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic wait_until_edge(input int target);
    int w;
    w = 0;
    while (edge_cnt < target && w < 100) begin
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    int   acc;
    vec_t busy_v;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(sqrt_done), 0);
    check("rst_sig", 32'(sqrt_proNorm_sig), 0);
    check("rst_exp", 32'(sqrt_proNorm_exp), 0);
    check("rst_uf", 32'(uf), 0);
    reset = 1'b1;

    // Directed vectors, issued back to back as soon as busy drops.
    foreach (vecs[i]) issue(vecs[i], 1'b1, acc);
    drain();

    // Kill mid-operation: busy drops, no completion, outputs hold.
    issue(vecs[1], 1'b0, acc);
    wait_until_edge(acc + 10);
    check("kill_busy_before", 32'(busy), 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_after", 32'(busy), 0);
    check("kill_hold_sig", 32'(sqrt_proNorm_sig), 32'(vecs[9].xs));
    check("kill_hold_exp", 32'(sqrt_proNorm_exp), 32'(vecs[9].xe));
    issue(vecs[0], 1'b1, acc);
    drain();

    // Kill and start together in IDLE: nothing launches.
    @(negedge clk);
    in_sig = 24'h800000; in_exp0 = 1'b1; is_subnormal = 1'b0; exp_half = 8'h7F;
    start = 1'b1;
    kill  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    check("kill_start_idle_busy", 32'(busy), 0);

    // Start while busy is ignored.
    issue(vecs[4], 1'b1, acc);
    wait_until_edge(acc + 3);
    busy_v = vecs[8];
    is_subnormal = busy_v.sub; in_exp0 = busy_v.e0; exp_half = busy_v.eh; in_sig = busy_v.s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset mid-operation.
    issue(vecs[6], 1'b0, acc);
    wait_until_edge(acc + 4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(sqrt_done), 0);
    check("arst_sig", 32'(sqrt_proNorm_sig), 0);
    check("arst_exp", 32'(sqrt_proNorm_exp), 0);
    check("arst_uf", 32'(uf), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    check("arst_idle_busy", 32'(busy), 0);

    // Recovery after reset.
    issue(vecs[2], 1'b1, acc);
    drain();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
